// File: rtl/key_debounce_10_pkg.sv
// Shared definitions for the ten-line key debouncer front end.
package key_debounce_10_pkg;

  localparam int N_KEYS = 10;

  typedef enum logic {
    S_STABLE = 1'b0,
    S_SETTLE = 1'b1
  } state_e;

  // A counter that must reach n-1 needs $clog2(n) bits, and always at least one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_10.sv
// Synchronises and debounces ten key lines as one vector, emitting press/release strobes.
// Optional auto-repeat of o_press is enabled by defining KEY_REPEAT_EN.
module key_debounce_10
  import key_debounce_10_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] i_keys,
  output logic [N_KEYS-1:0] o_keys,
  output logic              o_press,
  output logic              o_release,
  output logic              o_busy
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e            state, state_nxt;
  logic [N_KEYS-1:0] sync_keys;
  logic [N_KEYS-1:0] cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_KEYS-1:0] keys_q, keys_nxt;
  logic              commit_press, release_nxt;
  logic              press_q, release_q;
  logic              rpt_fire;

  sync_2ff #(.WIDTH(N_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_keys),
    .q     (sync_keys)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    cnt_nxt      = cnt;
    keys_nxt     = keys_q;
    commit_press = 1'b0;
    release_nxt  = 1'b0;
    case (state)
      S_STABLE: begin
        if (sync_keys != keys_q) begin
          cand_nxt  = sync_keys;
          cnt_nxt   = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync_keys != cand) begin
          cand_nxt = sync_keys;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          // A bounce back to the old value commits unchanged and both terms stay zero.
          keys_nxt     = cand;
          state_nxt    = S_STABLE;
          commit_press = |(cand & ~keys_q);
          release_nxt  = |(keys_q & ~cand);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_first, rpt_first_nxt;

  // Repeating only counts while the held vector is unchanged, so leaving S_STABLE never fires.
  always_comb begin
    rpt_cnt_nxt   = '0;
    rpt_first_nxt = 1'b1;
    rpt_fire      = 1'b0;
    if (state == S_STABLE && keys_q != '0 && sync_keys == keys_q) begin
      rpt_first_nxt = rpt_first;
      if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
        rpt_fire      = 1'b1;
        rpt_first_nxt = 1'b0;
      end else begin
        rpt_cnt_nxt = rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_first <= rpt_first_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_STABLE;
      cand      <= '0;
      cnt       <= '0;
      keys_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      keys_q    <= keys_nxt;
      press_q   <= commit_press | rpt_fire;
      release_q <= release_nxt;
    end
  end

  assign o_keys    = keys_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_busy    = (state == S_SETTLE);

endmodule

// File: tb/tb_key_debounce_10.sv
// Directed self-checking bench for key_debounce_10 (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
module tb_key_debounce_10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] i_keys;
  logic [9:0] o_keys;
  logic       o_press, o_release, o_busy;

  int checks   = 0;
  int failures = 0;

  key_debounce_10 #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_keys    (i_keys),
    .o_keys    (o_keys),
    .o_press   (o_press),
    .o_release (o_release),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new raw vector and check the commit lands exactly on edge 7.
  task automatic change_and_check(input string tag, input logic [9:0] old_v, input logic [9:0] new_v,
                                  input logic exp_p, input logic exp_r);
    i_keys = new_v;
    step(6);
    check({tag, "_pre_keys"}, o_keys, old_v);
    check({tag, "_pre_busy"}, 10'(o_busy), 10'd1);
    step(1);
    check({tag, "_keys"}, o_keys, new_v);
    check({tag, "_press"}, 10'(o_press), 10'(exp_p));
    check({tag, "_release"}, 10'(o_release), 10'(exp_r));
    check({tag, "_busy"}, 10'(o_busy), 10'd0);
    step(1);
    check({tag, "_press_once"}, 10'(o_press), 10'd0);
    check({tag, "_release_once"}, 10'(o_release), 10'd0);
  endtask

  initial begin
    int bad;
    int strobes;
    int presses;

    // Reset with all keys held.
    rst_n  = 1'b0;
    i_keys = 10'h3FF;
    step(3);
    check("rst_keys", o_keys, 10'h000);
    check("rst_press", 10'(o_press), 10'd0);
    check("rst_release", 10'(o_release), 10'd0);
    check("rst_busy", 10'(o_busy), 10'd0);
    rst_n = 1'b1;
    change_and_check("rst_commit", 10'h000, 10'h3FF, 1'b1, 1'b0);
    change_and_check("all_release", 10'h3FF, 10'h000, 1'b0, 1'b1);

    // Clean press and release of key 3.
    change_and_check("clean_press", 10'h000, 10'b0000001000, 1'b1, 1'b0);
    change_and_check("clean_release", 10'b0000001000, 10'h000, 1'b0, 1'b1);

    // Bounce on key 5: toggle every 2 cycles for 12 cycles, then hold.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      i_keys = (((i / 2) % 2) == 0) ? 10'b0000100000 : 10'h000;
      step(1);
      if (i >= 2 && (o_busy !== 1'b1 || o_keys !== 10'h000 || o_press !== 1'b0)) bad++;
    end
    check("bounce_hold_busy", 10'(bad), 10'd0);
    change_and_check("bounce_commit", 10'h000, 10'b0000100000, 1'b1, 1'b0);
    change_and_check("bounce_release", 10'b0000100000, 10'h000, 1'b0, 1'b1);

    // Glitch on key 9 for two cycles must be rejected.
    i_keys = 10'b1000000000;
    step(2);
    i_keys = 10'h000;
    bad = 0;
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (o_keys !== 10'h000) bad++;
      if (o_press || o_release) strobes++;
    end
    check("glitch_keys", 10'(bad), 10'd0);
    check("glitch_strobes", 10'(strobes), 10'd0);
    check("glitch_busy", 10'(o_busy), 10'd0);

    // Swap key 1 for key 8: both strobes in the commit cycle.
    change_and_check("swap_setup", 10'h000, 10'b0000000010, 1'b1, 1'b0);
    change_and_check("swap", 10'b0000000010, 10'b0100000000, 1'b1, 1'b1);

    // Async reset in the middle of a settle.
    i_keys = 10'h000;
    step(4);
    check("midsettle_busy", 10'(o_busy), 10'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_keys", o_keys, 10'h000);
    check("async_rst_busy", 10'(o_busy), 10'd0);
    check("async_rst_strobes", 10'({o_press, o_release}), 10'd0);
    step(2);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (o_press || o_release || o_busy) strobes++;
    end
    check("post_rst_quiet", 10'(strobes), 10'd0);

`ifdef KEY_REPEAT_EN
    // Auto-repeat: press at commit C, then C+8, C+12, C+16; release stops it.
    change_and_check("rpt_commit", 10'h000, 10'b0000000001, 1'b1, 1'b0);
    step(6);
    check("rpt_c7", 10'(o_press), 10'd0);
    step(1);
    check("rpt_c8", 10'(o_press), 10'd1);
    step(3);
    check("rpt_c11", 10'(o_press), 10'd0);
    step(1);
    check("rpt_c12", 10'(o_press), 10'd1);
    step(4);
    check("rpt_c16", 10'(o_press), 10'd1);
    i_keys  = 10'h000;
    presses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (o_press) presses++;
    end
    step(1);
    check("rpt_stop_presses", 10'(presses | int'(o_press)), 10'd0);
    check("rpt_release_keys", o_keys, 10'h000);
    check("rpt_release", 10'(o_release), 10'd1);
    presses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (o_press) presses++;
    end
    check("rpt_no_more", 10'(presses), 10'd0);
`else
    // Without auto-repeat a held key produces exactly one press.
    i_keys  = 10'b0000000001;
    presses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (o_press) presses++;
    end
    check("hold_single_press", 10'(presses), 10'd1);
    check("hold_keys", o_keys, 10'b0000000001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce_10.md
Name: key_debounce_10

Overview:
- Ten-line key front end that sits directly upstream of the 10-line to 4-line BCD priority encoder.
- Synchronises ten raw, bouncy, active-high key/switch lines and debounces them as one vector.
- Drives the clean, stable vector straight into the encoder input.
- Emits one-cycle press/release strobes so downstream logic can latch the encoded BCD value exactly once per key event.

Parameters:
- DEBOUNCE_CYCLES, 120000, cycles the synchronised vector must stay unchanged before it is committed (10 ms at 12 MHz); minimum 2.
- REPEAT_DELAY, 6000000, cycles a non-zero stable vector is held before the first auto-repeat press (used only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat presses (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- i_keys  input  10  raw asynchronous key lines, active-high, bit n = key n
- o_keys  output  10  debounced stable key vector; feeds encoder input i
- o_press  output  1  one-cycle strobe when a new key becomes stable-pressed (or on auto-repeat)
- o_release  output  1  one-cycle strobe when any stable-pressed key becomes released
- o_busy  output  1  high while a candidate change is settling

Behaviour:
- Reset:
  - Sync flops, candidate register, counters, o_keys, o_press, o_release and o_busy are all cleared to 0.
  - FSM goes to S_STABLE.
  - Reset asserted mid-settle discards the candidate; no strobes are produced.
- Synchroniser: two flops per bit. sync2 is the FSM input.
- Counter: width $clog2(DEBOUNCE_CYCLES). It saturates in logic only through the commit condition and never wraps.
- FSM:
  - S_STABLE:
    - If sync2 != o_keys: candidate <= sync2, cnt <= 0, go to S_SETTLE.
  - S_SETTLE (o_busy = 1):
    - If sync2 != candidate: candidate <= sync2, cnt <= 0, stay in S_SETTLE (bounce restarts the count).
    - Else if cnt == DEBOUNCE_CYCLES-1: commit. o_keys <= candidate, go to S_STABLE.
      - o_press = 1 for one cycle iff (candidate & ~old o_keys) != 0.
      - o_release = 1 for one cycle iff (old o_keys & ~candidate) != 0.
      - Both strobes may assert in the same cycle when one key is swapped for another.
    - Else cnt <= cnt+1.
    - Bounce back to the old value: the candidate then equals o_keys at commit. o_keys is rewritten unchanged and no strobes fire.
- Strobes are registered and are asserted in the same cycle o_keys updates.
- Latency:
  - Raw input stable before rising edge 1 gives o_keys, o_press and o_release updated after edge DEBOUNCE_CYCLES+3.
  - With DEBOUNCE_CYCLES=4, that is edge 7.
- Multiple simultaneous keys are passed through unchanged. Priority resolution belongs to the encoder.
- o_busy deasserts in the commit cycle.

Optional Feature:
- KEY_REPEAT_EN defined:
  - A repeat counter runs in S_STABLE while o_keys != 0.
  - It is cleared on every commit and whenever the FSM is in S_SETTLE or o_keys == 0.
  - o_press additionally pulses REPEAT_DELAY cycles after the commit, then every REPEAT_PERIOD cycles while held.
  - A release or new change stops repeating immediately: no repeat pulse occurs in or after the cycle the FSM leaves S_STABLE.
- KEY_REPEAT_EN undefined:
  - No repeat counter is synthesised.
  - o_press fires only on commit.
  - REPEAT_* parameters are ignored.

Decomposition:
- Shared header/package holds:
  - N_KEYS = 10
  - FSM state encodings S_STABLE/S_SETTLE
  - the clog2-based counter width helper
- One natural sub-module: sync_2ff (parameterised width, async active-low reset), instantiated once for the 10-bit vector. It is reused by other front-end blocks.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset: hold rst_n=0 with i_keys=10'h3FF -> all outputs 0. Release -> o_keys reaches 10'h3FF after edge 7 with one o_press pulse.
- Clean press/release:
  - i_keys 0 -> 10'b0000001000 -> o_keys=10'b0000001000 at edge 7, o_press single cycle.
  - Back to 0 -> o_keys=0 and a single o_release pulse, 7 edges later.
- Bounce: toggle i_keys bit 5 every 2 cycles for 12 cycles, then hold 1 -> o_keys stays 0 and o_busy stays 1 throughout; commit occurs 7 edges after the last toggle, with one o_press.
- Glitch rejection: pulse bit 9 high for 2 cycles, then return to 0 -> o_keys never changes, no strobes, o_busy returns to 0.
- Swap: stable 10'b0000000010, then change directly to 10'b0100000000 -> o_press and o_release both pulse in the same cycle as o_keys updates. Async reset asserted mid-settle -> outputs 0 immediately.
- KEY_REPEAT_EN: hold 10'b0000000001 -> o_press at commit, then at commit+8, +12, +16. Release -> repeat pulses stop.
